// File: rtl/clk_meas_pkg.sv
// rtl/clk_meas_pkg.sv - shared state encodings and gate-length defaults for clk_meas
//
// Purpose: state encoding and window-length constants used by the clk_meas block
// and its bench.
// Ports: none (package).

package clk_meas_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_GATE   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ARM    = ST_ARM,
    GATE   = ST_GATE,
    REPORT = ST_REPORT
  } state_e;

  // 1 ms window at a 50 MHz sys_clk
  localparam int GATE_CNT_DEFAULT = 50000;
  // short window used in simulation
  localparam int GATE_CNT_SIM = 100;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer plus delay flop with rising-edge detect
//
// Purpose: bring an asynchronous waveform into the clk_i domain and flag its
// rising edges. Every edge sees the same latency, so counts are unaffected.
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    synchronous active-low reset, clears all three flops
//   sig_i     asynchronous input waveform
//   sig_s_o   synchronized level
//   rise_o    one-cycle pulse on a synchronized 0->1 transition

module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic sig_s_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sig_s_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;

endmodule

// File: rtl/clk_meas.sv
// rtl/clk_meas.sv - gated edge/high-cycle counter with frequency-stable indicator
//
// Purpose: measures a generated clock (or slow test signal) on sys_clk. Each
// window is GATE_CNT cycles long and starts on the first synchronized rise;
// the window reports rising edges (frequency) and high cycles (duty), and a
// stable flag tracks whether successive edge counts agree within TOL.
// Ports:
//   sys_clk       system clock, rising edge
//   sys_rst_n     synchronous active-low reset
//   sig_in        asynchronous waveform under measurement
//   meas_en       1 = measure continuously, 0 = idle / abort
//   edge_cnt      rising edges in the last completed window
//   high_cnt      high cycles in the last completed window
//   result_valid  one-cycle pulse when edge_cnt/high_cnt update
//   stable        STABLE_N consecutive matching reports

module clk_meas
  import clk_meas_pkg::*;
#(
  parameter int GATE_CNT = GATE_CNT_DEFAULT,
  parameter int CNT_W    = 16,
  parameter int STABLE_N = 4,
  parameter int TOL      = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             result_valid,
  output logic             stable
);

  localparam int MW = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CNT);
  localparam logic [CNT_W-1:0] TOL_V      = CNT_W'(TOL);
  localparam logic [MW-1:0]    MATCH_FULL = MW'(STABLE_N);

  logic sig_s;
  logic rise;

  edge_sync u_edge_sync (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .sig_i   (sig_in),
    .sig_s_o (sig_s),
    .rise_o  (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_acc_q, edge_acc_d;
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             valid_q, valid_d;
  logic             stable_q, stable_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CNT_W-1:0] prev_edge_q, prev_edge_d;
  logic             prev_ok_q, prev_ok_d;

  logic [CNT_W-1:0] win_inc;
  logic [CNT_W-1:0] sig_s_w;
  logic [CNT_W-1:0] rise_w;
  logic [CNT_W-1:0] diff;
  logic             is_match;
  logic             report;
  logic             abort;

  assign win_inc = win_q + CNT_W'(1);
  assign sig_s_w = {{(CNT_W-1){1'b0}}, sig_s};
  assign rise_w  = {{(CNT_W-1){1'b0}}, rise};

  // The result registers load on the transition into REPORT, so edge_cnt,
  // high_cnt, result_valid and stable all change together in the REPORT cycle.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    edge_acc_d  = edge_acc_q;
    hi_acc_d    = hi_acc_q;
    edge_cnt_d  = edge_cnt_q;
    high_cnt_d  = high_cnt_q;
    valid_d     = 1'b0;
    stable_d    = stable_q;
    match_d     = match_q;
    prev_edge_d = prev_edge_q;
    prev_ok_d   = prev_ok_q;
    diff        = '0;
    is_match    = 1'b0;
    report      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        win_d      = '0;
        edge_acc_d = '0;
        hi_acc_d   = '0;
        prev_ok_d  = 1'b0;
        if (meas_en) state_d = ARM;
      end
      ARM: begin
        if (!meas_en) begin
          abort = 1'b1;
        end else if (rise) begin
          // the arming cycle is the first window cycle
          state_d    = GATE;
          win_d      = CNT_W'(1);
          edge_acc_d = CNT_W'(1);
          hi_acc_d   = CNT_W'(1);
        end else begin
          // no rise yet: count towards the timeout, tracking stuck-high time
          win_d      = win_inc;
          edge_acc_d = '0;
          hi_acc_d   = hi_acc_q + sig_s_w;
          if (win_inc == GATE_LAST) begin
            state_d = REPORT;
            report  = 1'b1;
          end
        end
      end
      GATE: begin
        if (!meas_en) begin
          abort = 1'b1;
        end else begin
          win_d      = win_inc;
          edge_acc_d = edge_acc_q + rise_w;
          hi_acc_d   = hi_acc_q + sig_s_w;
          if (win_inc == GATE_LAST) begin
            state_d = REPORT;
            report  = 1'b1;
          end
        end
      end
      REPORT: begin
        // a rise here is dropped; the next window needs a fresh one
        win_d      = '0;
        edge_acc_d = '0;
        hi_acc_d   = '0;
        state_d    = meas_en ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      win_d      = '0;
      edge_acc_d = '0;
      hi_acc_d   = '0;
      stable_d   = 1'b0;
      match_d    = '0;
      prev_ok_d  = 1'b0;
    end

    if (report) begin
      edge_cnt_d = edge_acc_d;
      high_cnt_d = hi_acc_d;
      valid_d    = 1'b1;
      diff       = (edge_acc_d >= prev_edge_q) ? (edge_acc_d - prev_edge_q)
                                               : (prev_edge_q - edge_acc_d);
      is_match   = prev_ok_q && (diff <= TOL_V);
      if ((edge_acc_d != '0) && is_match) begin
        match_d = (match_q == MATCH_FULL) ? match_q : match_q + MW'(1);
      end else begin
        match_d = (edge_acc_d != '0) ? MW'(1) : '0;
      end
      stable_d    = (match_d == MATCH_FULL);
      prev_edge_d = edge_acc_d;
      prev_ok_d   = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      edge_acc_q  <= '0;
      hi_acc_q    <= '0;
      edge_cnt_q  <= '0;
      high_cnt_q  <= '0;
      valid_q     <= 1'b0;
      stable_q    <= 1'b0;
      match_q     <= '0;
      prev_edge_q <= '0;
      prev_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      edge_acc_q  <= edge_acc_d;
      hi_acc_q    <= hi_acc_d;
      edge_cnt_q  <= edge_cnt_d;
      high_cnt_q  <= high_cnt_d;
      valid_q     <= valid_d;
      stable_q    <= stable_d;
      match_q     <= match_d;
      prev_edge_q <= prev_edge_d;
      prev_ok_q   <= prev_ok_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign high_cnt     = high_cnt_q;
  assign result_valid = valid_q;
  assign stable       = stable_q;

endmodule

// File: tb/tb_clk_meas.sv
// tb/tb_clk_meas.sv - self-checking bench for clk_meas with a window-level reference model

module tb_clk_meas;
  import clk_meas_pkg::*;

  localparam int GC = GATE_CNT_SIM;
  localparam int SN = 4;
  localparam int TL = 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        sig_in;
  logic        meas_en;
  logic [15:0] edge_cnt;
  logic [15:0] high_cnt;
  logic        result_valid;
  logic        stable;

  int n_pass  = 0;
  int n_total = 0;

  // waveform generator: 0 = low, 1 = high, 2 = periodic (per cycles, hi high)
  int mode  = 0;
  int per   = 10;
  int hi    = 5;
  int phase = 0;

  // edge counts reported since the last idle/reset
  int hist[$];

  clk_meas #(
    .GATE_CNT (GC),
    .CNT_W    (16),
    .STABLE_N (SN),
    .TOL      (TL)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sig_in       (sig_in),
    .meas_en      (meas_en),
    .edge_cnt     (edge_cnt),
    .high_cnt     (high_cnt),
    .result_valid (result_valid),
    .stable       (stable)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (mode == 0) sig_in = 1'b0;
    else if (mode == 1) sig_in = 1'b1;
    else begin
      sig_in = (phase < hi);
      phase  = (phase + 1 == per) ? 0 : phase + 1;
    end
    @(posedge sys_clk);
    #1;
  endtask

  // stable iff the last STABLE_N reports are nonzero and neighbours differ by <= TOL
  function automatic logic model_stable();
    int n = hist.size();
    if (n < SN) return 1'b0;
    for (int k = n - SN; k < n; k++) begin
      int d;
      if (hist[k] == 0) return 1'b0;
      if (k > n - SN) begin
        d = hist[k] - hist[k-1];
        if (d < 0) d = -d;
        if (d > TL) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic start_wave(input int p, input int h);
    mode = 0;
    repeat (4) tick();
    per   = p;
    hi    = h;
    phase = 0;
    mode  = 2;
  endtask

  // waits for one report and checks it; quiet silences the input before the
  // next sample so no stale rise can arm the following window
  task automatic do_report(input string tag, input int e, input int h,
                           input bit quiet, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!result_valid && lat < 400);
    check({tag, "_valid"}, result_valid, 1);
    hist.push_back(e);
    check({tag, "_edge"}, edge_cnt, e);
    check({tag, "_high"}, high_cnt, h);
    check({tag, "_stable"}, stable, model_stable());
    if (quiet) mode = 0;
    tick();
    check({tag, "_pulse"}, result_valid, 0);
  endtask

  task automatic segment(input string tag, input int p, input int h, input int n);
    int lat;
    start_wave(p, h);
    for (int r = 0; r < n; r++)
      do_report(tag, GC / p, (GC / p) * h, (r == n - 1), lat);
  endtask

  initial begin
    int lat;
    int pulses;
    int plist[7] = '{2, 4, 5, 10, 20, 25, 50};

    sys_rst_n = 1'b0;
    meas_en   = 1'b0;
    sig_in    = 1'b0;
    repeat (3) tick();
    check("rst_edge", edge_cnt, 0);
    check("rst_high", high_cnt, 0);
    check("rst_valid", result_valid, 0);
    check("rst_stable", stable, 0);

    sys_rst_n = 1'b1;
    meas_en   = 1'b1;
    segment("p10_d50", 10, 5, 4);
    segment("p20_d50", 20, 10, 4);
    segment("p10_d20", 10, 2, 2);
    segment("p2", 2, 1, 2);
    segment("p25", 25, 12, 2);
    segment("p20_tol", 20, 10, 3);

    for (int i = 0; i < 6; i++) begin
      int p = plist[$urandom_range(6)];
      int h = (p > 2) ? 1 + $urandom_range(p - 2) : 1;
      segment("rand", p, h, 1 + $urandom_range(2));
    end

    // abort mid-window after stable has been reached
    start_wave(10, 5);
    for (int r = 0; r < 4; r++) do_report("pre_abort", 10, 50, 1'b0, lat);
    repeat (50) tick();
    check("abort_stable_before", stable, 1);
    meas_en = 1'b0;
    tick();
    check("abort_stable", stable, 0);
    check("abort_valid", result_valid, 0);
    check("abort_edge_kept", edge_cnt, 10);
    check("abort_high_kept", high_cnt, 50);
    pulses = 0;
    repeat (120) begin
      tick();
      if (result_valid) pulses++;
    end
    check("abort_no_report", pulses, 0);
    hist.delete();

    // stuck low: timeout after enable -> ARM plus GATE_CNT ARM cycles
    mode = 0;
    repeat (5) tick();
    meas_en = 1'b1;
    do_report("stuck_lo", 0, 0, 1'b0, lat);
    check("stuck_lo_latency", lat, GC + 1);
    meas_en = 1'b0;
    repeat (3) tick();
    hist.delete();

    // stuck high: already high before arming, so no rise is ever seen
    mode = 1;
    repeat (5) tick();
    meas_en = 1'b1;
    do_report("stuck_hi", 0, GC, 1'b0, lat);
    check("stuck_hi_latency", lat, GC + 1);
    meas_en = 1'b0;
    repeat (3) tick();
    hist.delete();

    // reset asserted mid-window
    meas_en = 1'b1;
    start_wave(10, 5);
    do_report("pre_rst", 10, 50, 1'b0, lat);
    repeat (30) tick();
    sys_rst_n = 1'b0;
    tick();
    check("midrst_edge", edge_cnt, 0);
    check("midrst_high", high_cnt, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_stable", stable, 0);
    mode = 0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    hist.delete();
    pulses = 0;
    repeat (20) begin
      tick();
      if (result_valid) pulses++;
    end
    check("postrst_no_report", pulses, 0);
    per   = 10;
    hi    = 5;
    phase = 0;
    mode  = 2;
    do_report("postrst", 10, 50, 1'b0, lat);
    // one window plus the synchronizer delay from the first driven edge
    check("postrst_latency", (lat >= GC && lat <= GC + 4), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_meas.md
Name: clk_meas

Overview:
Single-clock measurement block that observes a generated clock waveform on sys_clk and reports its edge count (frequency) and high-cycle count (duty).
- Input is one of the PLL outputs: the multiplied, divided, phase-shifted or 20 %-duty clock, or any slow test signal.
- It sits on the consuming side of the clock-generation path.
- Results are used on-board to check the configured ratios and duty, and drive a "frequency stable" indicator.
- Valid for input frequencies up to sys_clk/2.

Parameters:
GATE_CNT, 50000, measurement window length in sys_clk cycles (1 ms at 50 MHz); must be < 2**CNT_W
CNT_W, 16, width of the window counter and of the result counters
STABLE_N, 4, number of consecutive matching reports required to assert stable
TOL, 1, allowed absolute edge_cnt difference between consecutive reports that still counts as matching

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  reset; one clock, synchronous, active-low
sig_in  in  1  asynchronous waveform under measurement
meas_en  in  1  level; 1 = measure continuously, 0 = idle
edge_cnt  out  CNT_W  rising edges counted in the last completed window
high_cnt  out  CNT_W  cycles sig_in sampled high in the last completed window
result_valid  out  1  one-cycle pulse when edge_cnt/high_cnt update
stable  out  1  level; frequency repeatable over STABLE_N reports

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - All outputs are 0, state is IDLE, and synchronizer and counters are cleared.
  - Reset asserted mid-window aborts the window; outputs are 0 on the next cycle.
- Input conditioning:
  - Two-flop synchronizer gives sig_s; a third flop gives sig_d.
  - rise = sig_s & ~sig_d.
  - Edge-to-rise latency is 3 sys_clk cycles, equal for all edges, so counts are unaffected.
- States:
  - IDLE: counters held at 0. meas_en=1 moves to ARM.
  - ARM: wait for the first rise, counting cycles in win_cnt and sig_s=1 cycles in hi_acc.
    - On rise: go to GATE with win_cnt=1, edge_acc=1, hi_acc=sig_s (=1). The window starts on the arming edge.
    - If win_cnt reaches GATE_CNT with no rise (timeout): go to REPORT with edge_acc=0 and hi_acc = cycles high during the timeout (0 if stuck low, GATE_CNT if stuck high).
  - GATE: each cycle win_cnt++, edge_acc += rise, hi_acc += sig_s.
    - After the cycle where win_cnt==GATE_CNT (exactly GATE_CNT cycles counted, arming cycle included), go to REPORT.
  - REPORT (1 cycle):
    - edge_cnt<=edge_acc, high_cnt<=hi_acc, result_valid=1.
    - Stable logic updates in the same cycle.
    - Next state is ARM if meas_en=1, else IDLE.
- meas_en=0 in ARM or GATE: abort to IDLE next cycle. No result_valid; stable clears to 0; edge_cnt/high_cnt keep their last values.
- Latency: result_valid is high in the cycle after the last window cycle. Back-to-back windows are separated by REPORT plus the re-arm wait.
- Arithmetic:
  - Accumulators are CNT_W bits.
  - edge_acc is bounded by GATE_CNT/2 and hi_acc by GATE_CNT, so overflow cannot occur.
  - Comparison uses |edge_acc - prev_edge| <= TOL, computed unsigned via subtraction in whichever order is non-negative.
- Stable:
  - match_cnt (0..STABLE_N) and prev_edge are registered.
  - On REPORT with edge_acc != 0 and match: match_cnt++ (saturating at STABLE_N). Otherwise match_cnt = 1 if edge_acc != 0, else 0.
  - The first report after IDLE or reset never matches, since prev_edge is invalid.
  - prev_edge <= edge_acc on every REPORT.
  - stable = (match_cnt == STABLE_N). It rises and falls only in REPORT cycles, except the meas_en abort, which clears it.
- Simultaneous events:
  - rise in the last GATE cycle is counted.
  - rise in REPORT is ignored, since the next ARM needs a fresh rise.
  - meas_en falling during REPORT still emits that report, then goes to IDLE.

Decomposition:
- Shared package clk_meas_pkg holds:
  - state encodings IDLE/ARM/GATE/REPORT (2-bit localparams);
  - default GATE_CNT for 50 MHz (50000);
  - simulation GATE_CNT (100).
- One sub-module, edge_sync: 2-flop synchronizer plus delay flop. Outputs sig_s and rise; sync active-low reset.

Test Plan:
All scenarios use sys_clk 20 ns, GATE_CNT=100, STABLE_N=4, TOL=1.
1. sig_in period 200 ns, high 100 ns -> edge_cnt=10, high_cnt=50, one result_valid pulse per window.
2. sig_in period 200 ns, high 40 ns (20 % duty) -> edge_cnt=10, high_cnt=20.
3. sig_in period 40 ns (sys_clk/2) -> edge_cnt=50, high_cnt=50. Stuck low -> after 100 ARM cycles report edge_cnt=0, high_cnt=0, stable=0. Stuck high -> high_cnt=100.
4. Steady 200 ns input -> stable rises in the cycle of the 4th result_valid. Switch to 400 ns -> next report edge_cnt=5 and stable=0 in that same cycle, re-asserting on the 4th 400 ns report.
5. meas_en dropped at window cycle 50 -> no result_valid, stable=0 next cycle, edge_cnt keeps its old value. sys_rst_n=0 mid-GATE -> all outputs 0 next cycle, and a new window starts only after reset release and the next rise.
